// File: rtl/mirfak_muldiv_pkg.sv
// Shared encodings for the M-extension issue logic: unit command codes,
// issue FSM states and the funct7 that marks an RV32M instruction.
package mirfak_muldiv_pkg;

    localparam logic [1:0] MULT_MUL    = 2'b00;
    localparam logic [1:0] MULT_MULH   = 2'b01;
    localparam logic [1:0] MULT_MULHSU = 2'b10;
    localparam logic [1:0] MULT_MULHU  = 2'b11;

    localparam logic [1:0] DIV_DIV  = 2'b00;
    localparam logic [1:0] DIV_DIVU = 2'b01;
    localparam logic [1:0] DIV_REM  = 2'b10;
    localparam logic [1:0] DIV_REMU = 2'b11;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_ISSUE = 2'd1,
        MD_WAIT  = 2'd2,
        MD_DONE  = 2'd3
    } md_state_e;

    // funct3[2] splits RV32M into the multiply group (0) and the divide group (1).
    function automatic logic is_div(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/mirfak_muldiv_issue.sv
// EX-stage initiator for the multiplier/divider. Latches the request, pulses the
// selected unit's enable, waits for its ack (or times out / gets killed), and
// holds the captured result until writeback takes it.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// MD_IDLE  | no operation in flight; a request latches operands/cmd
// MD_ISSUE | enable pulse to the selected unit, timeout counter cleared
// MD_WAIT  | waiting for ack; kill or timeout aborts back to idle
// MD_DONE  | result valid; leaves when writeback accepts or on kill
module mirfak_muldiv_issue
    import mirfak_muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    input  logic        ex_muldiv_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_rs1_i,
    input  logic [31:0] ex_rs2_i,
    input  logic        ex_kill_i,
    input  logic        wb_stall_i,
    output logic        ex_stall_o,
    output logic [31:0] md_result_o,
    output logic        md_valid_o,
    output logic        md_timeout_o,
    output logic [31:0] mult_op1,
    output logic [31:0] mult_op2,
    output logic [1:0]  mult_cmd,
    output logic        mult_enable,
    output logic        mult_abort,
    input  logic [31:0] mult_result,
    input  logic        mult_ack,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    output logic [1:0]  div_cmd,
    output logic        div_enable,
    output logic        div_abort,
    input  logic [31:0] div_result,
    input  logic        div_ack
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    md_state_e         state_q, state_d;
    logic              unit_q, unit_d;      // 1: divider selected
    logic [31:0]       mult_op1_q, mult_op1_d;
    logic [31:0]       mult_op2_q, mult_op2_d;
    logic [1:0]        mult_cmd_q, mult_cmd_d;
    logic [31:0]       div_op1_q, div_op1_d;
    logic [31:0]       div_op2_q, div_op2_d;
    logic [1:0]        div_cmd_q, div_cmd_d;
    logic [31:0]       result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              req;
    logic              ack_sel;
    logic [31:0]       result_sel;
    logic              enable_sel;
    logic              abort_sel;
    logic              timeout;

    assign req        = ex_valid_i & ex_muldiv_i & ~ex_kill_i;
    assign ack_sel    = unit_q ? div_ack : mult_ack;
    assign result_sel = unit_q ? div_result : mult_result;

    // Next-state, operand latching, result capture and timeout counting.
    always_comb begin
        state_d    = state_q;
        unit_d     = unit_q;
        mult_op1_d = mult_op1_q;
        mult_op2_d = mult_op2_q;
        mult_cmd_d = mult_cmd_q;
        div_op1_d  = div_op1_q;
        div_op2_d  = div_op2_q;
        div_cmd_d  = div_cmd_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        enable_sel = 1'b0;
        abort_sel  = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (req) begin
                    unit_d = is_div(ex_funct3_i);
                    if (is_div(ex_funct3_i)) begin
                        div_op1_d = ex_rs1_i;
                        div_op2_d = ex_rs2_i;
                        div_cmd_d = ex_funct3_i[1:0];
                    end else begin
                        mult_op1_d = ex_rs1_i;
                        mult_op2_d = ex_rs2_i;
                        mult_cmd_d = ex_funct3_i[1:0];
                    end
                    state_d = MD_ISSUE;
                end
            end
            MD_ISSUE: begin
                cnt_d = '0;
                if (ex_kill_i) begin
                    abort_sel = 1'b1;
                    state_d   = MD_IDLE;
                end else begin
                    enable_sel = 1'b1;
                    state_d    = MD_WAIT;
                end
            end
            MD_WAIT: begin
                if (ex_kill_i) begin
                    abort_sel = 1'b1;
                    state_d   = MD_IDLE;
                end else if (ack_sel) begin
                    result_d = result_sel;
                    state_d  = MD_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    abort_sel = 1'b1;
                    timeout   = 1'b1;
                    state_d   = MD_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MD_DONE: begin
                if (ex_kill_i || !wb_stall_i) begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // State, operand/command, result and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= MD_IDLE;
            unit_q     <= 1'b0;
            mult_op1_q <= '0;
            mult_op2_q <= '0;
            mult_cmd_q <= '0;
            div_op1_q  <= '0;
            div_op2_q  <= '0;
            div_cmd_q  <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            unit_q     <= unit_d;
            mult_op1_q <= mult_op1_d;
            mult_op2_q <= mult_op2_d;
            mult_cmd_q <= mult_cmd_d;
            div_op1_q  <= div_op1_d;
            div_op2_q  <= div_op2_d;
            div_cmd_q  <= div_cmd_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
        end
    end

    // Pulses are held low while reset is asserted so a reset mid-operation
    // never emits a stray enable or abort.
    assign mult_enable  = ~rst_i & enable_sel & ~unit_q;
    assign div_enable   = ~rst_i & enable_sel & unit_q;
    assign mult_abort   = ~rst_i & abort_sel & ~unit_q;
    assign div_abort    = ~rst_i & abort_sel & unit_q;
    assign md_timeout_o = ~rst_i & timeout;

    assign mult_op1    = mult_op1_q;
    assign mult_op2    = mult_op2_q;
    assign mult_cmd    = mult_cmd_q;
    assign div_op1     = div_op1_q;
    assign div_op2     = div_op2_q;
    assign div_cmd     = div_cmd_q;
    assign md_result_o = result_q;
    assign md_valid_o  = (state_q == MD_DONE);
    assign ex_stall_o  = req & ~((state_q == MD_DONE) & ~wb_stall_i);

endmodule

// File: tb/tb_mirfak_muldiv_issue.sv
// Directed bench for mirfak_muldiv_issue. A second instance with an 8-cycle
// timeout has its own valid input and is exercised only by the timeout case.
module tb_mirfak_muldiv_issue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ex_valid, ex_valid_t, ex_muldiv, ex_kill, wb_stall;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1, ex_rs2;
    logic        mult_ack, div_ack;
    logic [31:0] mult_result, div_result;

    logic        ex_stall, md_valid, md_timeout, mult_enable, mult_abort, div_enable, div_abort;
    logic [31:0] md_result, mult_op1, mult_op2, div_op1, div_op2;
    logic [1:0]  mult_cmd, div_cmd;

    logic        t_ex_stall, t_md_valid, t_md_timeout, t_mult_enable, t_mult_abort, t_div_enable, t_div_abort;
    logic [31:0] t_md_result, t_mult_op1, t_mult_op2, t_div_op1, t_div_op2;
    logic [1:0]  t_mult_cmd, t_div_cmd;

    int total = 0;
    int bad   = 0;

    mirfak_muldiv_issue u_dut (
        .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .ex_muldiv_i(ex_muldiv),
        .ex_funct3_i(ex_funct3), .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_kill_i(ex_kill),
        .wb_stall_i(wb_stall), .ex_stall_o(ex_stall), .md_result_o(md_result),
        .md_valid_o(md_valid), .md_timeout_o(md_timeout),
        .mult_op1(mult_op1), .mult_op2(mult_op2), .mult_cmd(mult_cmd),
        .mult_enable(mult_enable), .mult_abort(mult_abort),
        .mult_result(mult_result), .mult_ack(mult_ack),
        .div_op1(div_op1), .div_op2(div_op2), .div_cmd(div_cmd),
        .div_enable(div_enable), .div_abort(div_abort),
        .div_result(div_result), .div_ack(div_ack)
    );

    mirfak_muldiv_issue #(.TIMEOUT_CYCLES(8)) u_dut_to (
        .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid_t), .ex_muldiv_i(ex_muldiv),
        .ex_funct3_i(ex_funct3), .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_kill_i(ex_kill),
        .wb_stall_i(wb_stall), .ex_stall_o(t_ex_stall), .md_result_o(t_md_result),
        .md_valid_o(t_md_valid), .md_timeout_o(t_md_timeout),
        .mult_op1(t_mult_op1), .mult_op2(t_mult_op2), .mult_cmd(t_mult_cmd),
        .mult_enable(t_mult_enable), .mult_abort(t_mult_abort),
        .mult_result(mult_result), .mult_ack(mult_ack),
        .div_op1(t_div_op1), .div_op2(t_div_op2), .div_cmd(t_div_cmd),
        .div_enable(t_div_enable), .div_abort(t_div_abort),
        .div_result(div_result), .div_ack(div_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task step;
        @(posedge clk);
        #1;
    endtask

    // Unit models: compute from whatever operands the issuer presents at ack time.
    function automatic logic [31:0] mul_model(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (cmd == 2'b01 || cmd == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (cmd == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (cmd == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] div_model(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b);
        case (cmd)
            2'b00:   return 32'($signed(a) / $signed(b));
            2'b01:   return a / b;
            2'b10:   return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    // One complete operation: request, issue, ack after lat cycles, DONE held
    // for hold cycles of writeback stall, then hand-off. Ends in the cycle after
    // hand-off with the request still driven; the caller replaces or drops it.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] exp, input int hold);
        logic dv;
        dv = f3[2];
        ex_valid = 1'b1; ex_muldiv = 1'b1; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b;
        #1;
        chk("idle_stall", ex_stall, 1);
        chk("idle_no_en", {mult_enable, div_enable}, 0);
        step;
        chk("issue_en", dv ? div_enable : mult_enable, 1);
        chk("issue_other_en", dv ? mult_enable : div_enable, 0);
        chk("issue_abort", {mult_abort, div_abort}, 0);
        chk("issue_op1", dv ? div_op1 : mult_op1, a);
        chk("issue_op2", dv ? div_op2 : mult_op2, b);
        chk("issue_cmd", dv ? div_cmd : mult_cmd, f3[1:0]);
        for (int i = 1; i < lat; i++) begin
            step;
            ex_rs1 = ~a; ex_rs2 = ~b;
            #1;
            chk("wait_no_en", {mult_enable, div_enable}, 0);
            chk("wait_op1", dv ? div_op1 : mult_op1, a);
            chk("wait_valid", md_valid, 0);
            chk("wait_stall", ex_stall, 1);
        end
        step;
        if (dv) begin
            div_ack = 1'b1; div_result = div_model(div_cmd, div_op1, div_op2);
        end else begin
            mult_ack = 1'b1; mult_result = mul_model(mult_cmd, mult_op1, mult_op2);
        end
        #1;
        chk("ack_op1", dv ? div_op1 : mult_op1, a);
        chk("ack_op2", dv ? div_op2 : mult_op2, b);
        chk("ack_cmd", dv ? div_cmd : mult_cmd, f3[1:0]);
        chk("ack_valid", md_valid, 0);
        step;
        mult_ack = 1'b0; div_ack = 1'b0; ex_rs1 = a; ex_rs2 = b;
        for (int i = 0; i < hold; i++) begin
            wb_stall = 1'b1;
            #1;
            chk("hold_valid", md_valid, 1);
            chk("hold_result", md_result, exp);
            chk("hold_stall", ex_stall, 1);
            step;
        end
        wb_stall = 1'b0;
        #1;
        chk("done_valid", md_valid, 1);
        chk("done_result", md_result, exp);
        chk("done_stall", ex_stall, 0);
        chk("done_no_en", {mult_enable, div_enable}, 0);
        step;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_valid_t = 1'b0; ex_muldiv = 1'b0; ex_kill = 1'b0;
        wb_stall = 1'b0; ex_funct3 = 3'b0; ex_rs1 = '0; ex_rs2 = '0;
        mult_ack = 1'b0; div_ack = 1'b0; mult_result = '0; div_result = '0;
        repeat (3) step;
        rst = 1'b0;
        #1;
        chk("rst_valid", md_valid, 0);
        chk("rst_result", md_result, 0);
        chk("rst_ops", {mult_op1, mult_cmd, div_cmd}, 0);
        chk("rst_pulses", {mult_enable, mult_abort, div_enable, div_abort, md_timeout}, 0);
        chk("rst_stall", ex_stall, 0);
        step;

        // MUL 7*6, ack three cycles after enable
        run_op(3'b000, 32'd7, 32'd6, 3, 32'd42, 0);
        // MULHU and MULH back-to-back
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 32'hFFFF_FFFE, 0);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000, 0);
        // DIV -7/2 with a 33-cycle divider
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 0);
        ex_valid = 1'b0;
        step;

        // Kill the cycle before the expected ack
        ex_valid = 1'b1; ex_funct3 = 3'b000; ex_rs1 = 32'd9; ex_rs2 = 32'd9;
        step;
        step;
        step;
        ex_kill = 1'b1;
        #1;
        chk("kill_abort", mult_abort, 1);
        chk("kill_div_abort", div_abort, 0);
        chk("kill_no_en", mult_enable, 0);
        chk("kill_stall", ex_stall, 0);
        step;
        ex_kill = 1'b0; ex_valid = 1'b0; mult_ack = 1'b1; mult_result = 32'd81;
        #1;
        chk("late_ack_abort", mult_abort, 0);
        chk("late_ack_valid", md_valid, 0);
        step;
        mult_ack = 1'b0;
        #1;
        chk("kill_valid", md_valid, 0);
        chk("kill_result_kept", md_result, 32'hFFFF_FFFD);
        // FSM is idle again: a MULHSU is accepted immediately
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 2, 32'hFFFF_FFFF, 0);

        // Writeback stall for three cycles, then an immediate new MUL
        run_op(3'b000, 32'd100, 32'd3, 3, 32'd300, 3);
        run_op(3'b000, 32'd3, 32'd5, 1, 32'd15, 0);
        ex_valid = 1'b0;
        step;

        // Timeout on the 8-cycle instance; divider never acks
        ex_valid_t = 1'b1; ex_funct3 = 3'b100; ex_rs1 = 32'd5; ex_rs2 = 32'd0;
        #1;
        chk("to_req_stall", t_ex_stall, 1);
        step;
        chk("to_issue_en", t_div_enable, 1);
        for (int i = 1; i < 8; i++) begin
            step;
            chk("to_wait_quiet", {t_div_abort, t_md_timeout}, 0);
        end
        step;
        chk("to_abort", t_div_abort, 1);
        chk("to_pulse", t_md_timeout, 1);
        chk("to_no_en", t_div_enable, 0);
        chk("to_main_quiet", {div_abort, md_timeout}, 0);
        step;
        ex_valid_t = 1'b0;
        #1;
        chk("to_after_pulse", {t_div_abort, t_md_timeout}, 0);
        chk("to_stall_rel", t_ex_stall, 0);
        chk("to_valid", t_md_valid, 0);
        step;
        chk("to_no_reissue", t_div_enable, 0);

        // Reset during an in-flight divide
        ex_valid = 1'b1; ex_funct3 = 3'b101; ex_rs1 = 32'd100; ex_rs2 = 32'd7;
        step;
        step;
        rst = 1'b1; ex_kill = 1'b1;
        #1;
        chk("rst_mid_abort", {div_abort, mult_abort}, 0);
        step;
        rst = 1'b0; ex_kill = 1'b0; ex_valid = 1'b0;
        #1;
        chk("rst_mid_ops", div_op1, 0);
        chk("rst_mid_result", md_result, 0);
        chk("rst_mid_valid", md_valid, 0);
        step;
        chk("rst_mid_no_en", {div_enable, mult_enable}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
